// File: rtl/mdlsm_batch_sequencer.sv
// Batch sequencer for the MDLSM `main` core.
// Steps file_index across [first_idx, last_idx]. For each file it pulses
// start, waits for finish, and then moves to the next index. A per-file
// watchdog and an abort input can end the batch early. The result is
// reported through done, error, files_done and fail_idx.
//
// Handshakes:
//   req/busy : req is sampled only while busy is low (IDLE). A request seen
//              while busy is high is dropped, not queued.
//   start/finish : start is held high for START_CYCLES cycles. A file
//              completes when finish is high, but only after finish has
//              been seen low at least once since that file's start. This
//              keeps a finish level left over from the previous file from
//              completing the next one.
module mdlsm_batch_sequencer #(
   parameter int IDX_W        = 10,
   parameter int START_CYCLES = 3,
   parameter int TIMEOUT      = 4096,
   parameter int TO_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [IDX_W-1:0] first_idx,
   input  logic [IDX_W-1:0] last_idx,
   input  logic             abort,
   input  logic             finish,
   output logic             start,
   output logic [IDX_W-1:0] file_index,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [IDX_W:0]   files_done,
   output logic [IDX_W-1:0] fail_idx
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam int               SC_W    = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(START_CYCLES - 1);
   localparam logic [SC_W-1:0]  SC_ONE  = SC_W'(1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W:0]   FD_ONE  = (IDX_W + 1)'(1);
   localparam bit               WD_EN   = (TIMEOUT != 0);

   logic [2:0]       state;
   logic [SC_W-1:0]  st_cnt;   // remaining start cycles after the current one
   logic [TO_W-1:0]  wd_cnt;   // cycles spent in WAIT for the current file
   logic [IDX_W-1:0] last_q;   // only the upper bound is needed after acceptance
   logic             arm;      // finish has been seen low since this file's start
   logic             complete;
   logic             wd_expired;

   // Completion needs finish high after it has been seen low for this file.
   // The watchdog fires on the last allowed WAIT cycle.
   always_comb begin
      complete   = arm & finish;
      wd_expired = WD_EN && (wd_cnt == TO_LAST);
   end

   // Sequencer FSM. Every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         start      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         files_done <= '0;
         file_index <= '0;
         fail_idx   <= '0;
         last_q     <= '0;
         arm        <= 1'b0;
         st_cnt     <= '0;
         wd_cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  busy       <= 1'b1;
                  files_done <= '0;
                  if (first_idx <= last_idx) begin
                     last_q     <= last_idx;
                     file_index <= first_idx;
                     error      <= 1'b0;
                     arm        <= 1'b0;
                     st_cnt     <= SC_LAST;
                     start      <= 1'b1;
                     state      <= S_START;
                  end else begin
                     // An empty range is reported as an error at first_idx.
                     error    <= 1'b1;
                     fail_idx <= first_idx;
                     done     <= 1'b1;
                     state    <= S_DONE;
                  end
               end
            end
            S_START: begin
               if (abort) begin
                  start <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  if (!finish) arm <= 1'b1;
                  if (st_cnt == '0) begin
                     start  <= 1'b0;
                     wd_cnt <= '0;
                     state  <= S_WAIT;
                  end else begin
                     st_cnt <= st_cnt - SC_ONE;
                  end
               end
            end
            S_WAIT: begin
               if (abort) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else if (complete) begin
                  state <= S_NEXT;
               end else if (wd_expired) begin
                  error    <= 1'b1;
                  fail_idx <= file_index;
                  done     <= 1'b1;
                  state    <= S_DONE;
               end else begin
                  if (!finish) arm <= 1'b1;
                  wd_cnt <= wd_cnt + TO_ONE;
               end
            end
            S_NEXT: begin
               if (abort) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  files_done <= files_done + FD_ONE;
                  // Compare before incrementing, so a range that ends at the
                  // top index stops instead of wrapping to zero.
                  if (file_index == last_q) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     file_index <= file_index + IDX_ONE;
                     arm        <= 1'b0;
                     st_cnt     <= SC_LAST;
                     start      <= 1'b1;
                     state      <= S_START;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               start <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdlsm_batch_sequencer.sv
// Bench for mdlsm_batch_sequencer.
// Directed batches are run against a behavioural model of `main`.
// Expected start indices and done results go into queues when a batch is
// issued. A negedge monitor pops them and compares when the DUT shows start
// rising or done high. Instance u_dut_to uses a short watchdog (16 cycles)
// for the timeout case.
module tb_mdlsm_batch_sequencer;

   localparam int SC = 3;

   logic        clk;
   logic        rst, req, abort, finish, sel;
   logic [9:0]  first_idx, last_idx;
   logic        req_a, req_b;

   logic        a_start, a_busy, a_done, a_error;
   logic [9:0]  a_file_index, a_fail_idx;
   logic [10:0] a_files_done;
   logic        b_start, b_busy, b_done, b_error;
   logic [9:0]  b_file_index, b_fail_idx;
   logic [10:0] b_files_done;

   logic        m_start, m_busy, m_done, m_error;
   logic [9:0]  m_file_index, m_fail_idx;
   logic [10:0] m_files_done;

   logic [9:0]  start_q[$];
   logic [21:0] done_q[$];   // {files_done[10:0], error, fail_idx[9:0]}

   int n_checks = 0;
   int n_errors = 0;

   assign req_a = req & ~sel;
   assign req_b = req & sel;

   assign m_start      = sel ? b_start      : a_start;
   assign m_busy       = sel ? b_busy       : a_busy;
   assign m_done       = sel ? b_done       : a_done;
   assign m_error      = sel ? b_error      : a_error;
   assign m_file_index = sel ? b_file_index : a_file_index;
   assign m_fail_idx   = sel ? b_fail_idx   : a_fail_idx;
   assign m_files_done = sel ? b_files_done : a_files_done;

   mdlsm_batch_sequencer #(.IDX_W(10), .START_CYCLES(3), .TIMEOUT(4096), .TO_W(16)) u_dut (
      .clk(clk), .rst(rst), .req(req_a), .first_idx(first_idx), .last_idx(last_idx),
      .abort(abort), .finish(finish), .start(a_start), .file_index(a_file_index),
      .busy(a_busy), .done(a_done), .error(a_error), .files_done(a_files_done),
      .fail_idx(a_fail_idx)
   );

   mdlsm_batch_sequencer #(.IDX_W(10), .START_CYCLES(3), .TIMEOUT(16), .TO_W(16)) u_dut_to (
      .clk(clk), .rst(rst), .req(req_b), .first_idx(first_idx), .last_idx(last_idx),
      .abort(abort), .finish(finish), .start(b_start), .file_index(b_file_index),
      .busy(b_busy), .done(b_done), .error(b_error), .files_done(b_files_done),
      .fail_idx(b_fail_idx)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      n_checks++;
      n_errors++;
      $display("FAIL %s: observed value %0d, expected no event", name, act);
   endtask

   // ---------------- model of `main` ----------------
   // After each start rising edge it drops finish mdl_drop cycles later and
   // raises it mdl_rise cycles after that. The raise is skipped for the
   // hang index. For the abort index, abort is raised together with finish.
   logic [9:0] mdl_idx, hang_idx, ab_idx;
   logic       mdl_prev, hang_en, ab_en;
   int         mdl_drop, mdl_rise;

   initial begin
      finish   = 1'b0;
      abort    = 1'b0;
      mdl_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (m_start && !mdl_prev) begin
            mdl_idx = m_file_index;
            repeat (mdl_drop) @(negedge clk);
            finish = 1'b0;
            if (!(hang_en && (mdl_idx == hang_idx))) begin
               repeat (mdl_rise) @(negedge clk);
               finish = 1'b1;
               if (ab_en && (mdl_idx == ab_idx)) begin
                  abort = 1'b1;
                  @(negedge clk);
                  abort = 1'b0;
                  check("abort_done_next_cycle", 32'(m_done), 1);
                  check("abort_start_low", 32'(m_start), 0);
               end
            end
         end
         mdl_prev = m_start;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic        prev_start = 1'b0;
   logic        prev_done  = 1'b0;
   int          start_len  = 0;
   logic [9:0]  mon_idx;
   logic [21:0] mon_done;

   always @(negedge clk) begin
      if (m_start) start_len++;
      if (m_start && !prev_start) begin
         if (start_q.size() == 0) fail_now("start_unexpected", 32'(m_file_index));
         else begin
            mon_idx = start_q.pop_front();
            check("start_index", 32'(m_file_index), 32'(mon_idx));
         end
      end
      if (!m_start && prev_start) begin
         check("start_length", start_len, SC);
         start_len = 0;
      end
      if (m_done) begin
         if (done_q.size() == 0) fail_now("done_unexpected", 32'(m_files_done));
         else begin
            mon_done = done_q.pop_front();
            check("files_done", 32'(m_files_done), 32'(mon_done[21:11]));
            check("error", 32'(m_error), 32'(mon_done[10]));
            if (mon_done[10]) check("fail_idx", 32'(m_fail_idx), 32'(mon_done[9:0]));
            check("busy_in_done", 32'(m_busy), 1);
         end
      end
      if (prev_done) check("busy_after_done", 32'(m_busy), 0);
      prev_start = m_start;
      prev_done  = m_done;
   end

   // ---------------- driver tasks ----------------
   task automatic push_done(input logic [10:0] fd, input logic err, input logic [9:0] fi);
      done_q.push_back({fd, err, fi});
   endtask

   // Called on a negedge; returns on the negedge after the request was sampled.
   task automatic drive_req(input logic [9:0] f, input logic [9:0] l);
      req       = 1'b1;
      first_idx = f;
      last_idx  = l;
      @(negedge clk);
      req = 1'b0;
   endtask

   // Counts cycles until done is seen, up to a limit, then waits one more cycle.
   task automatic wait_done(input int max, output int n);
      n = 0;
      while (!m_done && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!m_done) fail_now("done_timeout", 32'(n));
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   int n;

   initial begin
      rst = 1'b1; req = 1'b0; first_idx = '0; last_idx = '0; sel = 1'b0;
      mdl_drop = 2; mdl_rise = 20; hang_en = 1'b0; hang_idx = '0;
      ab_en = 1'b0; ab_idx = '0;
      repeat (5) @(negedge clk);
      check("rst_start", 32'(a_start), 0);
      check("rst_busy", 32'(a_busy), 0);
      check("rst_done", 32'(a_done), 0);
      check("rst_error", 32'(a_error), 0);
      check("rst_files_done", 32'(a_files_done), 0);
      check("rst_file_index", 32'(a_file_index), 0);
      check("rst_fail_idx", 32'(a_fail_idx), 0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: indices 1..2, finish drops 2 cycles after start and rises 20 later.
      start_q.push_back(10'd1);
      start_q.push_back(10'd2);
      push_done(11'd2, 1'b0, 10'd0);
      drive_req(10'd1, 10'd2);
      wait_done(200, n);
      check("t1_latency", n, 48);

      // Test 2: finish is still high from test 1. It must not complete the file early.
      mdl_drop = 4; mdl_rise = 6;
      start_q.push_back(10'd5);
      push_done(11'd1, 1'b0, 10'd0);
      drive_req(10'd5, 10'd5);
      wait_done(100, n);
      check("t2_latency", n, 12);

      // Test 3: 16-cycle watchdog. Index 8 never completes.
      sel = 1'b1; mdl_drop = 2; mdl_rise = 5; hang_en = 1'b1; hang_idx = 10'd8;
      start_q.push_back(10'd7);
      start_q.push_back(10'd8);
      push_done(11'd1, 1'b1, 10'd8);
      drive_req(10'd7, 10'd9);
      n = 0;
      while (!(m_start && m_file_index == 10'd8) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!(m_start && m_file_index == 10'd8)) fail_now("t3_start8_timeout", 32'(n));
      wait_done(100, n);
      check("t3_start_to_done", n, SC + 16);
      hang_en = 1'b0;
      sel = 1'b0;
      @(negedge clk);

      // Test 4: empty range. done follows right away and start never goes high.
      push_done(11'd0, 1'b1, 10'd3);
      drive_req(10'd3, 10'd2);
      check("t4_done_immediate", 32'(m_done), 1);
      check("t4_no_start", 32'(m_start), 0);
      wait_done(5, n);
      check("t4_latency", n, 0);

      // Test 5: abort on the same cycle finish rises for index 2.
      ab_en = 1'b1; ab_idx = 10'd2;
      start_q.push_back(10'd0);
      start_q.push_back(10'd1);
      start_q.push_back(10'd2);
      push_done(11'd2, 1'b0, 10'd0);
      drive_req(10'd0, 10'd3);
      wait_done(200, n);
      ab_en = 1'b0;
      start_q.push_back(10'd10);
      push_done(11'd1, 1'b0, 10'd0);
      drive_req(10'd10, 10'd10);
      wait_done(100, n);

      // Test 6: top of the index range, with no wrap to 0.
      start_q.push_back(10'd1021);
      start_q.push_back(10'd1022);
      start_q.push_back(10'd1023);
      push_done(11'd3, 1'b0, 10'd0);
      drive_req(10'd1021, 10'd1023);
      wait_done(200, n);

      // Test 6b: reset in the middle of WAIT. No done pulse should follow.
      hang_en = 1'b1; hang_idx = 10'd4;
      start_q.push_back(10'd4);
      drive_req(10'd4, 10'd4);
      n = 0;
      while (m_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("t6_busy_before_rst", 32'(m_busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("t6_rst_start", 32'(m_start), 0);
      check("t6_rst_busy", 32'(m_busy), 0);
      check("t6_rst_done", 32'(m_done), 0);
      check("t6_rst_file_index", 32'(m_file_index), 0);
      check("t6_rst_files_done", 32'(m_files_done), 0);
      rst = 1'b0;
      hang_en = 1'b0;
      repeat (10) @(negedge clk);

      check("start_q_empty", 32'(start_q.size()), 0);
      check("done_q_empty", 32'(done_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Bound on total simulation time.
   initial begin
      #100000;
      $display("FAIL global_timeout: simulation time %0t, expected completion earlier", $time);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mdlsm_batch_sequencer.md
Name: mdlsm_batch_sequencer

Overview:
- Sequences the `main` MDLSM processing core over a contiguous range of file indices.
- Per file: drives file_index, pulses start for a fixed number of cycles, then waits for finish before advancing.
- Adds a per-file timeout watchdog, abort, and completion/error reporting.
- Sits directly above `main`, replacing testbench-driven sequencing in system integration.

Parameters:
- IDX_W, 10, width of file_index and range bounds.
- START_CYCLES, 3, cycles start is held high per file (≥1).
- TIMEOUT, 4096, max cycles in WAIT per file; 0 disables the watchdog.
- TO_W, 16, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  batch request; sampled only in IDLE.
- first_idx  in  IDX_W  first file index; latched on accepted req.
- last_idx  in  IDX_W  last file index, inclusive; latched on accepted req.
- abort  in  1  terminate batch; level, sampled each cycle.
- finish  in  1  from `main`; level, high when current file is complete.
- start  out  1  to `main`.
- file_index  out  IDX_W  to `main`.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at batch end (normal, abort, error).
- error  out  1  sticky; cleared on next accepted req.
- files_done  out  IDX_W+1  count of files completed in the current batch.
- fail_idx  out  IDX_W  index that timed out; valid while error is high.

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; start, busy, done, error = 0; files_done = 0; file_index = 0; fail_idx = 0.
  - Mid-batch reset drops start at that same edge; no done pulse is generated.
- States: IDLE, START, WAIT, NEXT, DONE. All outputs are registered.
- IDLE:
  - On req with first_idx ≤ last_idx: latch both bounds, file_index ← first_idx, files_done ← 0, error ← 0, arm ← 0, go to START.
  - On req with first_idx > last_idx: error ← 1, fail_idx ← first_idx, go to DONE. files_done is 0.
  - req while busy is ignored.
- START:
  - start=1 for exactly START_CYCLES cycles; a counter reloads on each entry. Then go to WAIT with start=0.
  - finish is not evaluated for completion here, but finish=0 sets arm.
- WAIT:
  - Completion requires arm=1 and finish=1. The arm flag is set on any cycle since START entry where finish=0, so a stale high finish from the previous file is never accepted.
  - Watchdog counter starts at 0 on entry and increments per cycle. If TIMEOUT≠0 and the count reaches TIMEOUT with no completion: error ← 1, fail_idx ← file_index, go to DONE.
  - Completion → NEXT.
- NEXT (1 cycle):
  - files_done ← files_done+1.
  - If file_index == latched last → DONE. Otherwise file_index ← file_index+1 → START.
  - The compare happens before the increment, so last=2^IDX_W−1 terminates without wrap.
- DONE (1 cycle): done=1, then IDLE. file_index, files_done, error, fail_idx hold until the next accepted req.
- abort=1 in START/WAIT/NEXT:
  - Next state is DONE; start=0 from that edge.
  - error is unaffected, and the in-flight file is not counted.
  - abort wins over a simultaneous completion or timeout.
  - abort in IDLE/DONE is ignored.
- Per-file overhead: START_CYCLES + 1 (NEXT) cycles plus the wait until finish.

Test Plan:
1. Reset 5 cycles, req with first=1, last=2; model `main` drops finish 2 cycles after start and raises it 20 cycles later → start pulses 3 cycles each for indices 1 then 2; done pulses once; files_done=2; error=0; busy is low only after done.
2. first=5, last=5, with finish held high from a prior run and dropped 4 cycles after start → no early completion on the stale high; exactly one file; files_done=1.
3. TIMEOUT=16, first=7, last=9; model never raises finish on index 8 → error=1, fail_idx=8, files_done=1, done pulse 16 cycles after WAIT entry for index 8; start is never issued for index 9.
4. first=3, last=2 → done pulse 1 cycle after req; error=1; fail_idx=3; start never asserted.
5. first=0, last=3; abort asserted in the same cycle finish rises for index 2 → files_done=2; done next cycle; start=0; error=0. Following req with 10..10 clears state and processes index 10.
6. first=1021, last=1023 → indices 1021, 1022, 1023 processed; files_done=3; no wrap to 0. Separately, rst asserted mid-WAIT → start=0, busy=0, no done pulse.
